// File: rtl/pong_char_pkg.sv
// Shared constants, state encoding and helpers for the score character encoder.
package pong_char_pkg;

    localparam int CHAR_W = 6;
    localparam logic [CHAR_W-1:0] CHAR_SPACE = 6'd36;
    localparam logic [CHAR_W-1:0] CHAR_QMARK = 6'd63;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SHIFT  = 2'd1;
    localparam state_t FORMAT = 2'd2;

    // Largest score that fits in the given number of decimal digits.
    function automatic int unsigned max_decimal(input int unsigned digits);
        int unsigned m;
        m = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more.
module bcd_nibble_adj (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/score_char_encoder.sv
// Serial binary-to-decimal converter producing per-digit glyph codes for the score renderers.
//
//   state  | meaning
//   IDLE   | waiting for Load, Chars holds the last result
//   SHIFT  | one double-dabble step per cycle, SCORE_W cycles
//   FORMAT | BCD complete, glyph codes registered into Chars on exit
module score_char_encoder
    import pong_char_pkg::*;
#(
    parameter int SCORE_W     = 10,
    parameter int DIGITS      = 3,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SCORE_W-1:0]         Score,
    input  logic                       Load,
    output logic [CHAR_W*DIGITS-1:0]   Chars,
    output logic                       Busy,
    output logic                       Done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam int unsigned MAX_SCORE = max_decimal(DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCORE_W - 1);

    function automatic logic [CHAR_W*DIGITS-1:0] reset_chars();
        logic [CHAR_W*DIGITS-1:0] r;
        r = '0;
        for (int k = 1; k < DIGITS; k++) begin
            r[CHAR_W*k +: CHAR_W] = BLANK_ZEROS ? CHAR_SPACE : '0;
        end
        return r;
    endfunction

    localparam logic [CHAR_W*DIGITS-1:0] CHARS_RST = reset_chars();

    state_t                   state;
    logic [SCORE_W-1:0]       shift_reg;
    logic [BCD_W-1:0]         bcd;
    logic [BCD_W-1:0]         bcd_adj;
    logic [CNT_W-1:0]         cnt;
    logic                     over_flag;
    logic                     pend;
    logic [SCORE_W-1:0]       pend_val;
    logic [SCORE_W-1:0]       start_val;
    logic                     start_over;
    logic [CHAR_W*DIGITS-1:0] chars_fmt;
    logic                     lead;
    logic [3:0]               digit;
    logic                     unused_carry;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .nibble   (bcd[4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    // Anything shifted past the top nibble is beyond DIGITS and is covered by the overflow flag.
    assign unused_carry = bcd_adj[BCD_W-1];

    // A fresh Load always beats an older queued request.
    assign start_val  = Load ? Score : pend_val;
    assign start_over = (32'(start_val) > MAX_SCORE);

    always_comb begin
        chars_fmt = '0;
        lead      = 1'b1;
        digit     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            digit = bcd[4*k +: 4];
            if (over_flag) begin
                chars_fmt[CHAR_W*k +: CHAR_W] = CHAR_QMARK;
            end else if (BLANK_ZEROS && lead && (k != 0) && (digit == 4'd0)) begin
                chars_fmt[CHAR_W*k +: CHAR_W] = CHAR_SPACE;
            end else begin
                chars_fmt[CHAR_W*k +: CHAR_W] = CHAR_W'(digit);
                lead = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bcd       <= '0;
            cnt       <= '0;
            over_flag <= 1'b0;
            pend      <= 1'b0;
            pend_val  <= '0;
            Chars     <= CHARS_RST;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Load) begin
                        shift_reg <= start_val;
                        over_flag <= start_over;
                        bcd       <= '0;
                        cnt       <= '0;
                        Busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (Load) begin
                        pend     <= 1'b1;
                        pend_val <= Score;
                    end
                    bcd       <= {bcd_adj[BCD_W-2:0], shift_reg[SCORE_W-1]};
                    shift_reg <= {shift_reg[SCORE_W-2:0], 1'b0};
                    cnt       <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state <= FORMAT;
                    end
                end
                FORMAT: begin
                    Chars <= chars_fmt;
                    Done  <= 1'b1;
                    if (Load || pend) begin
                        shift_reg <= start_val;
                        over_flag <= start_over;
                        bcd       <= '0;
                        cnt       <= '0;
                        pend      <= 1'b0;
                        state     <= SHIFT;
                    end else begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/score_char_encoder.md
Name: score_char_encoder

Overview:
- Sequential binary-to-decimal converter that turns a binary score into per-digit 6-bit character codes for the glyph renderers (one renderer instance per digit, fed through its Value input).
- Sits between game logic (score counters) and the on-screen digit renderers.
- Uses iterative shift-add-3 (double dabble), one bit per cycle. Handles leading-zero blanking, overflow marking and load-while-busy queuing.

Parameters:
- SCORE_W, 10, width of the binary score input.
- DIGITS, 3, number of decimal digits produced.
- BLANK_ZEROS, 1: when 1, leading zeros become the space code; the units digit is never blanked.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); acts immediately, independent of clk.
- Score  in  SCORE_W  binary score, sampled only on an accepted Load.
- Load  in  1  single-cycle request to convert Score.
- Chars  out  6*DIGITS  character codes. Chars[5:0] = units, Chars[11:6] = tens, Chars[6k+5:6k] = digit k. Registered.
- Busy  out  1  high while a conversion is in flight or queued.
- Done  out  1  one-cycle pulse, asserted in the same cycle Chars first shows a new result.

Behaviour:
- Reset values:
  - Chars: units = 0; all other digits = 36 (space) if BLANK_ZEROS = 1, else 0.
  - Busy = 0, Done = 0.
  - FSM = IDLE; pending flag cleared; shift register, BCD register and bit counter cleared.
- FSM states and transitions:
  - IDLE: on Load = 1 at edge N, capture Score into the shift register, clear BCD and counter, go to SHIFT. Busy = 1 from edge N.
  - SHIFT: each cycle, first add 3 to every BCD nibble >= 5, then shift {BCD, shiftreg} left by 1. Counter increments. After SCORE_W cycles, go to FORMAT.
  - FORMAT (one cycle): compute digit codes from BCD and register them into Chars at the exiting edge. Assert Done for exactly the following cycle.
    - If a pending request or a Load is present in FORMAT, go directly to SHIFT with that value; Busy stays 1.
    - Otherwise go to IDLE; Busy falls together with the Done pulse.
- Latency: Load sampled at edge N → Chars/Done valid after edge N+SCORE_W+1 (11 cycles at defaults).
- Chars holds its previous value for the whole conversion. It never shows partial results.
- Load while not IDLE:
  - The value is stored as pending and the pending flag is set.
  - A later Load overwrites the pending value (latest wins).
  - A Load in FORMAT takes priority over an older pending value.
  - At most one request is queued.
- Digit formatting:
  - Digit codes 0-9 equal the decimal digit value.
  - Overflow: if the captured score > 10^DIGITS - 1, every digit = 63 ('?' glyph). Detection is a compare against a constant derived from DIGITS at elaboration time. BCD nibbles above DIGITS are discarded.
  - Blanking (BLANK_ZEROS = 1): scanning from the most significant digit, zero digits become 36 until the first non-zero digit. The units digit always shows its numeric value.
- Width rules:
  - BCD register width = 4*DIGITS.
  - Counter width = clog2(SCORE_W+1).
  - No truncation of Score on capture.
- Reset asserted mid-conversion: all state returns to reset values immediately, the pending request is discarded and no Done is produced.

Decomposition:
- Package pong_char_pkg:
  - CHAR_W = 6, CHAR_SPACE = 36, CHAR_QMARK = 63.
  - A function returning 10^DIGITS - 1.
  - FSM state typedef {IDLE, SHIFT, FORMAT}.
- Sub-module bcd_nibble_adj: combinational add-3-if->=5 for one nibble, instanced DIGITS times inside a generate loop.

Test Plan:
- Reset released, no Load → Chars = {36,36,0}, Busy = 0, Done = 0 for 20 cycles.
- Load with Score = 7 → Busy high from next edge; after exactly 11 cycles Done pulses for one cycle; Chars = {36,36,7}; Busy low in the Done cycle.
- Sequential Loads of 905, 100, 0, 10 → Chars = {9,0,5}, {1,0,0}, {36,36,0}, {36,1,0}.
- Load 999 → {9,9,9}; Load 1000 → {63,63,63}; Load 1023 → {63,63,63}.
- Load 42, then Load 5 at cycle +3 and Load 17 at cycle +6 → exactly two Done pulses: first with Chars = {36,4,2}, second 11 cycles later with {36,1,7}; Busy continuously high between them.
- Load 500, then assert reset at cycle +4 → Chars = {36,36,0} and Busy = 0 immediately with no clock edge needed; no Done ever occurs for 500.
